// File: rtl/line_clear_engine.sv
// Tetris line-clear engine: scans the grid bottom-up over memory port A, drops full rows,
// compacts the surviving rows downward and zero-fills the vacated rows at the top.
module line_clear_engine #(
  parameter int COLS  = 10,
  parameter int ROWS  = 20,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] lines_cleared,
  output logic [7:0]       mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             mem_we,
  input  logic [7:0]       mem_rdata
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK_RD,
    S_CHK_WT,
    S_CPY_RD,
    S_CPY_WT,
    S_CPY_WR,
    S_FILL,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    src_q, src_d;
  logic [RW-1:0]    dst_q, dst_d;
  logic [CW-1:0]    col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lines_q, lines_d;
  logic [7:0]       data_q, data_d;
  logic             dst_wrap_q, dst_wrap_d;

  function automatic logic [7:0] cell_addr(input logic [RW-1:0] row, input logic [CW-1:0] col);
    logic [15:0] a;
    a = 16'(row) * 16'(COLS) + 16'(col);
    return a[7:0];
  endfunction

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      lines_q    <= '0;
      data_q     <= '0;
      dst_wrap_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      lines_q    <= lines_d;
      data_q     <= data_d;
      dst_wrap_q <= dst_wrap_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    lines_d    = lines_q;
    data_d     = data_q;
    dst_wrap_d = dst_wrap_q;
    mem_addr   = 8'd0;
    mem_wdata  = 8'd0;
    mem_we     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d      = LAST_ROW;
          dst_d      = LAST_ROW;
          col_d      = '0;
          cnt_d      = '0;
          dst_wrap_d = 1'b0;
          state_d    = S_CHK_RD;
        end
      end

      S_CHK_RD: begin
        mem_addr = cell_addr(src_q, col_q);
        state_d  = S_CHK_WT;
      end

      S_CHK_WT: begin
        if (mem_rdata == 8'd0) begin
          col_d = '0;
          if (src_q == dst_q) begin
            // Row already in place: step past it without touching memory.
            src_d      = src_q - RW'(1);
            dst_d      = dst_q - RW'(1);
            dst_wrap_d = (dst_q == '0);
            state_d    = (src_q == '0) ? S_FILL : S_CHK_RD;
          end else begin
            state_d = S_CPY_RD;
          end
        end else if (col_q == LAST_COL) begin
          cnt_d   = cnt_q + CNT_W'(1);
          col_d   = '0;
          src_d   = src_q - RW'(1);
          state_d = (src_q == '0) ? S_FILL : S_CHK_RD;
        end else begin
          col_d   = col_q + CW'(1);
          state_d = S_CHK_RD;
        end
      end

      S_CPY_RD: begin
        mem_addr = cell_addr(src_q, col_q);
        state_d  = S_CPY_WT;
      end

      S_CPY_WT: begin
        data_d  = mem_rdata;
        state_d = S_CPY_WR;
      end

      S_CPY_WR: begin
        mem_addr  = cell_addr(dst_q, col_q);
        mem_wdata = data_q;
        mem_we    = 1'b1;
        if (col_q == LAST_COL) begin
          // dst sits above src here, so it cannot be row 0.
          col_d   = '0;
          src_d   = src_q - RW'(1);
          dst_d   = dst_q - RW'(1);
          state_d = (src_q == '0) ? S_FILL : S_CHK_RD;
        end else begin
          col_d   = col_q + CW'(1);
          state_d = S_CPY_RD;
        end
      end

      S_FILL: begin
        if (dst_wrap_q) begin
          state_d = S_DONE;
        end else begin
          mem_addr = cell_addr(dst_q, col_q);
          mem_we   = 1'b1;
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (dst_q == '0) begin
              dst_wrap_d = 1'b1;
              state_d    = S_DONE;
            end else begin
              dst_d = dst_q - RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end

      S_DONE: begin
        lines_d = cnt_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign lines_cleared = (state_q == S_DONE) ? cnt_q : lines_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine: behavioural grid memory, table of scenarios with
// hand-computed spot values, a row-compaction reference for the full grid, plus corner sequences.
module tb_line_clear_engine;

  localparam int COLS  = 10;
  localparam int ROWS  = 20;
  localparam int CNT_W = 5;
  localparam int CELLS = ROWS * COLS;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             busy, done, mem_we;
  logic [CNT_W-1:0] lines_cleared;
  logic [7:0]       mem_addr, mem_wdata, mem_rdata;

  logic             tb_we;
  logic [7:0]       tb_addr, tb_wdata;
  logic [7:0]       mem     [256];
  logic [7:0]       init_g  [CELLS];
  logic [7:0]       exp_g   [CELLS];

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  int we_seen = 0;

  line_clear_engine #(.COLS(COLS), .ROWS(ROWS), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_addr] <= tb_wdata;
    mem_rdata <= mem[mem_addr];
    if (done) done_seen <= done_seen + 1;
    if (mem_we) we_seen <= we_seen + 1;
  end

  typedef struct {
    int tid;
    int exp_lines;
  } run_t;

  typedef struct {
    int tid;
    int addr;
    int val;
  } spot_t;

  run_t  runs  [5];
  spot_t spots [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic write_cell(input int a, input logic [7:0] v);
    tb_we = 1'b1;
    tb_addr = 8'(a);
    tb_wdata = v;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic load_grid(input int tid);
    for (int a = 0; a < CELLS; a++) init_g[a] = 8'd0;
    case (tid)
      2: begin
        for (int a = 190; a < 200; a++) init_g[a] = 8'd3;
        init_g[180] = 8'd5;
      end
      3: begin
        for (int c = 0; c < COLS; c++) begin
          init_g[160 + c] = 8'd1;
          init_g[180 + c] = 8'd1;
        end
        init_g[199] = 8'd9;
        init_g[170] = 8'd7;
        init_g[150] = 8'd4;
      end
      4: for (int a = 0; a < CELLS; a++) init_g[a] = 8'hFF;
      5: begin
        for (int a = 0; a < 10; a++) init_g[a] = 8'd2;
        init_g[15]  = 8'd6;
        init_g[199] = 8'd1;
      end
      default: ;
    endcase
    for (int a = 0; a < CELLS; a++) write_cell(a, init_g[a]);
  endtask

  // Reference: keep non-full rows in bottom-up order, everything above them empty.
  task automatic ref_compact();
    int d;
    bit full;
    d = ROWS - 1;
    for (int a = 0; a < CELLS; a++) exp_g[a] = 8'd0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (init_g[r*COLS + c] == 8'd0) full = 1'b0;
      if (!full) begin
        for (int c = 0; c < COLS; c++) exp_g[d*COLS + c] = init_g[r*COLS + c];
        d--;
      end
    end
  endtask

  task automatic check_grid(input string name);
    int bad;
    bad = 0;
    for (int a = 0; a < CELLS; a++) if (mem[a] !== exp_g[a]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  // Pulses start, waits for done; optionally re-pulses start while busy.
  task automatic run(input string name, input bit extra_start, output int cycles);
    int d0;
    d0 = done_seen;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    check({name, " busy_after_start"}, 32'(busy), 32'd1);
    while (!done && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (extra_start && cycles == 10) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    check({name, " done_timeout"}, 32'(done), 32'd1);
    @(negedge clk);
    check({name, " busy_after_done"}, 32'(busy), 32'd0);
    repeat (60) @(negedge clk);
    check({name, " done_count"}, 32'(done_seen - d0), 32'd1);
  endtask

  initial begin
    int cycles;
    int w0;
    int d0;
    int k;

    runs[0] = '{1, 0};
    runs[1] = '{2, 1};
    runs[2] = '{3, 2};
    runs[3] = '{4, 20};
    runs[4] = '{5, 1};

    spots[0]  = '{1, 0, 0};
    spots[1]  = '{1, 199, 0};
    spots[2]  = '{2, 190, 5};
    spots[3]  = '{2, 191, 0};
    spots[4]  = '{2, 199, 0};
    spots[5]  = '{2, 180, 0};
    spots[6]  = '{3, 199, 9};
    spots[7]  = '{3, 180, 7};
    spots[8]  = '{3, 170, 4};
    spots[9]  = '{3, 150, 0};
    spots[10] = '{3, 165, 0};
    spots[11] = '{4, 0, 0};
    spots[12] = '{4, 199, 0};
    spots[13] = '{5, 0, 0};
    spots[14] = '{5, 9, 0};
    spots[15] = '{5, 15, 6};
    spots[16] = '{5, 199, 1};

    reset = 1'b1;
    start = 1'b0;
    tb_we = 1'b0;
    tb_addr = 8'd0;
    tb_wdata = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset lines", 32'(lines_cleared), 32'd0);
    check("reset we", 32'(mem_we), 32'd0);
    check("reset addr", 32'(mem_addr), 32'd0);
    check("reset wdata", 32'(mem_wdata), 32'd0);

    for (int i = 0; i < 5; i++) begin
      string nm;
      nm = $sformatf("t%0d", runs[i].tid);
      load_grid(runs[i].tid);
      ref_compact();
      w0 = we_seen;
      run(nm, 1'b0, cycles);
      check({nm, " lines"}, 32'(lines_cleared), 32'(runs[i].exp_lines));
      check_grid({nm, " grid"});
      for (int s = 0; s < 17; s++)
        if (spots[s].tid == runs[i].tid)
          check($sformatf("%s cell%0d", nm, spots[s].addr), 32'(mem[spots[s].addr]),
                32'(spots[s].val));
      if (runs[i].tid == 1) begin
        check("t1 cycles_le_43", 32'(cycles <= 2*ROWS + 3), 32'd1);
        check("t1 no_writes", 32'(we_seen - w0), 32'd0);
      end
    end

    // start re-pulsed while busy must be ignored.
    load_grid(2);
    ref_compact();
    run("t6 start_busy", 1'b1, cycles);
    check("t6 lines", 32'(lines_cleared), 32'd1);
    check_grid("t6 grid");

    // Reset while the copy loop is writing.
    load_grid(3);
    d0 = done_seen;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!mem_we && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("t6 reached_cpy_wr", 32'(mem_we), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t6 rst busy", 32'(busy), 32'd0);
    check("t6 rst we", 32'(mem_we), 32'd0);
    check("t6 rst done", 32'(done), 32'd0);
    check("t6 rst lines", 32'(lines_cleared), 32'd0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("t6 no_done_after_rst", 32'(done_seen - d0), 32'd0);
    check("t6 idle_after_rst", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
